// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller: opcodes, FSM states,
// slice operation encodings and the decoded slice-control record.
package alu_pkg;

    // ALU_control opcode values
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;

    // 1-bit slice operation select
    localparam logic [1:0] SLICE_AND  = 2'd0;
    localparam logic [1:0] SLICE_OR   = 2'd1;
    localparam logic [1:0] SLICE_ADD  = 2'd2;
    localparam logic [1:0] SLICE_LESS = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSltFix,
        StFin
    } state_e;

    // Slice controls plus the flags the controller needs per opcode
    typedef struct packed {
        logic       a_invert;
        logic       b_invert;
        logic       cin0;
        logic [1:0] operation;
        logic       legal;
        logic       arith;       // reports carry-out
        logic       signed_ovf;  // reports overflow (ADD/SUB only)
        logic       slt;
    } ctrl_t;

endpackage

// File: rtl/alu_top.sv
// 1-bit ALU slice: optional operand inversion, AND/OR/ADD/LESS select, full-adder carry.
module alu_top
    import alu_pkg::*;
(
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);

    logic a;
    logic b;
    logic sum;

    // Slice result select and carry generation
    always_comb begin
        a    = src1 ^ a_invert;
        b    = src2 ^ b_invert;
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
        case (operation)
            SLICE_AND: result = a & b;
            SLICE_OR:  result = a | b;
            SLICE_ADD: result = sum;
            default:   result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial WIDTH-bit ALU: one alu_top slice, one bit per clock LSB first,
// registered carry chain, start/done handshake toward issue and write-back.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALU_control_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    function automatic ctrl_t decode(input logic [3:0] code);
        ctrl_t c;
        c = '0;
        case (code)
            OP_AND: c.operation = SLICE_AND;
            OP_OR:  c.operation = SLICE_OR;
            OP_ADD: begin c.operation = SLICE_ADD; c.arith = 1'b1; c.signed_ovf = 1'b1; end
            OP_SUB: begin
                c.b_invert = 1'b1; c.cin0 = 1'b1; c.operation = SLICE_ADD;
                c.arith = 1'b1; c.signed_ovf = 1'b1;
            end
            OP_NOR: begin c.a_invert = 1'b1; c.b_invert = 1'b1; c.operation = SLICE_AND; end
            OP_SLT: begin
                c.b_invert = 1'b1; c.cin0 = 1'b1; c.operation = SLICE_ADD;
                c.arith = 1'b1; c.slt = 1'b1;
            end
            default: c.operation = SLICE_AND;
        endcase
        // every listed opcode is legal; anything else decodes to all-zero controls
        c.legal = (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) ||
                  (code == OP_SUB) || (code == OP_NOR) || (code == OP_SLT);
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, result_q;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, set_q, cout_pend_q, ovf_pend_q, ill_pend_q;
    logic             done_q, zero_q, cout_q, ovf_q, ill_q;
    ctrl_t            ctrl;
    logic             slice_res, slice_cout, last_bit, msb_ovf;

    // In IDLE decode the incoming opcode, otherwise the latched one
    assign ctrl     = decode((state_q == StIdle) ? ALU_control_i : op_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign msb_ovf  = carry_q ^ slice_cout;

    alu_top u_slice (
        .src1      (a_q[cnt_q]),
        .src2      (b_q[cnt_q]),
        .less      (1'b0),
        .a_invert  (ctrl.a_invert),
        .b_invert  (ctrl.b_invert),
        .cin       (carry_q),
        .operation (ctrl.operation),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_i) state_d = ctrl.legal ? StRun : StFin;
            StRun:    if (last_bit) state_d = ctrl.slt ? StSltFix : StFin;
            StSltFix: state_d = StFin;
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Operand capture, serial datapath and publication of results on completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            set_q       <= 1'b0;
            cout_pend_q <= 1'b0;
            ovf_pend_q  <= 1'b0;
            ill_pend_q  <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: if (start_i) begin
                    a_q         <= src1_i;
                    b_q         <= src2_i;
                    op_q        <= ALU_control_i;
                    cnt_q       <= '0;
                    carry_q     <= ctrl.cin0;
                    res_q       <= '0;
                    set_q       <= 1'b0;
                    cout_pend_q <= 1'b0;
                    ovf_pend_q  <= 1'b0;
                    ill_pend_q  <= ~ctrl.legal;
                end
                StRun: begin
                    res_q[cnt_q] <= slice_res;
                    carry_q      <= slice_cout;
                    if (last_bit) begin
                        cout_pend_q <= slice_cout & ctrl.arith;
                        ovf_pend_q  <= msb_ovf & ctrl.signed_ovf;
                        set_q       <= slice_res ^ msb_ovf;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSltFix: res_q <= {{(WIDTH-1){1'b0}}, set_q};
                StFin: begin
                    result_q <= res_q;
                    zero_q   <= (res_q == '0);
                    cout_q   <= cout_pend_q;
                    ovf_q    <= ovf_pend_q;
                    ill_q    <= ill_pend_q;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
    assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed vector bench for alu_serial_ctrl (WIDTH = 32).
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src1, src2;
    logic [3:0]  alu_ctrl;
    logic        busy, done, zero, cout, ovf, ill;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .src1_i        (src1),
        .src2_i        (src2),
        .ALU_control_i (alu_ctrl),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .zero_o        (zero),
        .cout_o        (cout),
        .overflow_o    (ovf),
        .illegal_o     (ill)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        il;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op; lat = clock edges from accept edge until done seen
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        alu_ctrl = op; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (!done && !busy) busy_ok = 1'b0;
            if (done && busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int  lat;
        bit  bok;
        int  dcount;

        vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 33};
        vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0, 33};
        vecs[2]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 33};
        vecs[3]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1, 0, 0, 34};
        vecs[4]  = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 1, 0, 0, 34};
        vecs[5]  = '{4'b1100, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 0, 0, 0, 0, 33};
        vecs[6]  = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 0, 1, 1};
        vecs[7]  = '{4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0, 33};
        vecs[8]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0, 33};
        vecs[9]  = '{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0, 33};
        vecs[10] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 0, 34};
        vecs[11] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 0, 33};

        rst_n = 1'b0; start = 1'b0; src1 = '0; src2 = '0; alu_ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {25'd0, result, zero, cout, ovf, ill, done, busy}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
            chk($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
            chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].z));
            chk($sformatf("v%0d_cout", i), 64'(cout), 64'(vecs[i].c));
            chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].v));
            chk($sformatf("v%0d_illegal", i), 64'(ill), 64'(vecs[i].il));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
            @(posedge clk);
            #1 chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // start re-asserted mid-RUN and during FIN must be ignored
        @(negedge clk);
        alu_ctrl = 4'b0010; src1 = 32'h7FFFFFFF; src2 = 32'h00000001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bok = 1'b1;
        dcount = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
            if (k <= 32 && !busy) bok = 1'b0;
            if (k == 10) begin start = 1'b1; alu_ctrl = 4'b0000; src1 = '0; src2 = '0; end
            if (k == 11) start = 1'b0;
            if (k == 32) begin start = 1'b1; alu_ctrl = 4'b0110; src1 = 32'd9; src2 = 32'd9; end
            if (k == 33) begin
                start = 1'b0;
                chk("ign_done_at_33", 64'(done), 64'd1);
                chk("ign_result", 64'(result), 64'h80000000);
                chk("ign_ovf", 64'(ovf), 64'd1);
            end
        end
        chk("ign_busy_continuous", 64'(bok), 64'd1);
        chk("ign_done_count", 64'(dcount), 64'd1);

        // async reset in the middle of an ADD
        run_op(4'b0010, 32'd1, 32'd2, lat, bok);
        chk("pre_rst_result", 64'(result), 64'd3);
        @(negedge clk);
        alu_ctrl = 4'b0010; src1 = 32'h7FFFFFFF; src2 = 32'h00000001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs", {25'd0, result, zero, cout, ovf, ill, done, busy}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 if (done) dcount++;
        end
        chk("rst_no_done", 64'(dcount), 64'd0);
        run_op(4'b0010, 32'h00000064, 32'h000000C8, lat, bok);
        chk("post_rst_result", 64'(result), 64'h12C);
        chk("post_rst_latency", 64'(lat), 64'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
